// File: rtl/ladybird_axi_ram_slave.sv
// ladybird_axi_ram_slave: AXI4-Lite responder backed by a word-addressed RAM.
// Serves one transaction at a time; reads take priority over writes in IDLE.
// Read data appears READ_LATENCY cycles after the AR handshake.
// Optional feature macro: LADYBIRD_AXI_RAM_ERROR_EN. When it is defined,
// out-of-range word indices return SLVERR. When it is undefined, indices
// alias modulo DEPTH_WORDS.
module ladybird_axi_ram_slave #(
  parameter int unsigned DEPTH_WORDS  = 4096,
  parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned READ_LATENCY = 1,
  parameter              INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] awaddr,
  input  logic        wvalid,
  output logic        wready,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        bvalid,
  input  logic        bready,
  output logic [1:0]  bresp
);

  localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned CW = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [2:0] {IDLE, R_WAIT, R_RESP, W_DATA, B_RESP} state_t;

  state_t         state_q, state_d;
  logic [29:0]    idx_q;
  logic [CW-1:0]  cnt_q;
  logic [31:0]    rdata_q;
  logic [1:0]     rresp_q, bresp_q;
  logic [31:0]    mem [DEPTH_WORDS];

  logic [31:0]    ar_off, aw_off;
  logic [29:0]    rd_idx;
  logic           rd_oor, wr_oor, rd_load;
  logic           ar_hs, aw_hs, w_hs;
  logic           unused_bits;

  assign ar_off = araddr - BASE_ADDR;
  assign aw_off = awaddr - BASE_ADDR;
  // The AR index is used directly when the read is launched from IDLE.
  // This lets a READ_LATENCY of 1 sample the RAM on the handshake edge.
  assign rd_idx = (state_q == IDLE) ? ar_off[31:2] : idx_q;

`ifdef LADYBIRD_AXI_RAM_ERROR_EN
  assign rd_oor = ({2'b00, rd_idx} >= 32'(DEPTH_WORDS));
  assign wr_oor = ({2'b00, idx_q}  >= 32'(DEPTH_WORDS));
`else
  assign rd_oor = 1'b0;
  assign wr_oor = 1'b0;
`endif

  assign unused_bits = ^{ar_off[1:0], aw_off[1:0], rd_idx, idx_q};

  assign ar_hs   = arready & arvalid;
  assign aw_hs   = awready & awvalid;
  assign w_hs    = wready & wvalid;
  assign rd_load = (state_d == R_RESP) && (state_q != R_RESP);

  assign rdata = nrst ? rdata_q : '0;
  assign rresp = nrst ? rresp_q : '0;
  assign bresp = nrst ? bresp_q : '0;

  // State register
  always_ff @(posedge clk) begin
    if (!nrst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state and handshake outputs; everything is held low while in reset
  always_comb begin
    state_d = state_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    rvalid  = 1'b0;
    bvalid  = 1'b0;
    case (state_q)
      IDLE: begin
        arready = 1'b1;
        awready = ~arvalid;
        if (arvalid)      state_d = (READ_LATENCY <= 1) ? R_RESP : R_WAIT;
        else if (awvalid) state_d = W_DATA;
      end
      R_WAIT: if (cnt_q == CW'(1)) state_d = R_RESP;
      R_RESP: begin
        rvalid = 1'b1;
        if (rready) state_d = IDLE;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) state_d = B_RESP;
      end
      B_RESP: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!nrst) begin
      state_d = IDLE;
      arready = 1'b0;
      awready = 1'b0;
      wready  = 1'b0;
      rvalid  = 1'b0;
      bvalid  = 1'b0;
    end
  end

  // Address latch, latency counter and registered response fields
  always_ff @(posedge clk) begin
    if (!nrst) begin
      idx_q   <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      bresp_q <= '0;
    end else begin
      if (ar_hs) begin
        idx_q <= ar_off[31:2];
        cnt_q <= CW'(READ_LATENCY - 1);
      end else if (aw_hs) begin
        idx_q <= aw_off[31:2];
      end else if (state_q == R_WAIT) begin
        cnt_q <= cnt_q - CW'(1);
      end
      if (rd_load) begin
        rdata_q <= rd_oor ? '0 : mem[rd_idx[AW-1:0]];
        rresp_q <= rd_oor ? 2'b10 : 2'b00;
      end
      if (w_hs) bresp_q <= wr_oor ? 2'b10 : 2'b00;
    end
  end

  // Byte-lane RAM write on the W handshake; RAM contents survive reset
  always_ff @(posedge clk) begin
    if (w_hs && !wr_oor) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[idx_q[AW-1:0]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_ladybird_axi_ram_slave.sv
// Directed bench for ladybird_axi_ram_slave built with READ_LATENCY=3.
module tb_ladybird_axi_ram_slave;

  logic        clk = 1'b0;
  logic        nrst;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] araddr, awaddr, rdata, wdata;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;

  int vectors = 0;
  int miscompares = 0;

  ladybird_axi_ram_slave #(
    .DEPTH_WORDS (4096),
    .BASE_ADDR   (32'h0000_0000),
    .READ_LATENCY(3),
    .INIT_FILE   ("")
  ) dut (
    .clk(clk), .nrst(nrst),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, output logic [1:0] resp);
    int n;
    awaddr = addr; awvalid = 1'b1;
    n = 0;
    while (!awready && n < 20) begin tick(); n++; end
    chk("aw_wait", 32'(n < 20), 32'd1);
    tick();
    awvalid = 1'b0;
    wdata = data; wstrb = strb; wvalid = 1'b1;
    n = 0;
    while (!wready && n < 20) begin tick(); n++; end
    tick();
    wvalid = 1'b0;
    chk("b_latency", 32'(bvalid), 32'd1);
    n = 0;
    while (!bvalid && n < 20) begin tick(); n++; end
    resp = bresp;
    bready = 1'b1;
    tick();
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output int lat);
    int n;
    araddr = addr; arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin tick(); n++; end
    tick();
    arvalid = 1'b0;
    lat = 1;
    while (!rvalid && lat < 20) begin tick(); lat++; end
    data = rdata; resp = rresp;
    rready = 1'b1;
    tick();
    rready = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;

    nrst = 1'b0;
    arvalid = 1'b0; araddr = '0; rready = 1'b0;
    awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; wstrb = '0;
    bready = 1'b0;
    tick(); tick();

    // Reset state
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_bresp",   32'(bresp),   32'd0);
    nrst = 1'b1;
    tick();
    chk("idle_arready", 32'(arready), 32'd1);
    chk("idle_awready", 32'(awready), 32'd1);
    wvalid = 1'b1;
    #1;
    chk("w_before_aw", 32'(wready), 32'd0);
    wvalid = 1'b0;

    // T1 full-word write/read
    axi_write(32'h100, 32'hDEADBEEF, 4'hF, r);
    chk("t1_bresp", 32'(r), 32'd0);
    axi_read(32'h100, d, r, lat);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", 32'(r), 32'd0);
    chk("t1_lat", 32'(lat), 32'd3);

    // T2 byte strobe, unaligned address bits ignored
    axi_write(32'h101, 32'h0000AA00, 4'b0010, r);
    axi_read(32'h100, d, r, lat);
    chk("t2_rdata", d, 32'hDEADAAEF);

    // T3 read wins over a simultaneous write
    arvalid = 1'b1; araddr = 32'h100;
    awvalid = 1'b1; awaddr = 32'h200;
    #1;
    chk("t3_arready", 32'(arready), 32'd1);
    chk("t3_awready", 32'(awready), 32'd0);
    tick();
    arvalid = 1'b0;
    chk("t3_aw_held", 32'(awready), 32'd0);
    for (int i = 0; i < 20 && !rvalid; i++) tick();
    chk("t3_rdata", rdata, 32'hDEADAAEF);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("t3_aw_after_r", 32'(awready), 32'd1);
    tick();
    awvalid = 1'b0;
    wdata = 32'h55667788; wstrb = 4'hF; wvalid = 1'b1;
    #1;
    chk("t3_wready", 32'(wready), 32'd1);
    tick();
    wvalid = 1'b0;
    chk("t3_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    axi_read(32'h200, d, r, lat);
    chk("t3_rdata_w", d, 32'h55667788);

    // T4 latency and backpressure
    arvalid = 1'b1; araddr = 32'h200;
    tick();
    arvalid = 1'b0;
    chk("t4_rvalid_n1", 32'(rvalid), 32'd0);
    tick();
    chk("t4_rvalid_n2", 32'(rvalid), 32'd0);
    tick();
    chk("t4_rvalid_n3", 32'(rvalid), 32'd1);
    for (int i = 0; i < 7; i++) begin
      tick();
      chk("t4_hold_valid", 32'(rvalid), 32'd1);
      chk("t4_hold_data", rdata, 32'h55667788);
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    chk("t4_arready_after", 32'(arready), 32'd1);
    chk("t4_rvalid_after", 32'(rvalid), 32'd0);

    // T5 out-of-range / aliasing
    axi_write(32'h0, 32'h12345678, 4'hF, r);
    axi_write(32'h4, 32'h11112222, 4'hF, r);
    axi_read(32'h4000, d, r, lat);
`ifdef LADYBIRD_AXI_RAM_ERROR_EN
    chk("t5_rdata", d, 32'h0);
    chk("t5_rresp", 32'(r), 32'd2);
`else
    chk("t5_rdata", d, 32'h12345678);
    chk("t5_rresp", 32'(r), 32'd0);
`endif
    axi_write(32'h4004, 32'hCAFEF00D, 4'hF, r);
    axi_read(32'h4, d, r, lat);
`ifdef LADYBIRD_AXI_RAM_ERROR_EN
    chk("t5_wr_rdata", d, 32'h11112222);
`else
    chk("t5_wr_rdata", d, 32'hCAFEF00D);
`endif

    // T6 reset while waiting on read latency
    arvalid = 1'b1; araddr = 32'h100;
    tick();
    arvalid = 1'b0;
    nrst = 1'b0;
    #1;
    chk("t6_rst_rvalid", 32'(rvalid), 32'd0);
    chk("t6_rst_arready", 32'(arready), 32'd0);
    tick();
    nrst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t6_no_rvalid", 32'(rvalid), 32'd0);
    end
    chk("t6_idle", 32'(arready), 32'd1);
    axi_read(32'h100, d, r, lat);
    chk("t6_rdata", d, 32'hDEADAAEF);

    // Reset before the W handshake drops the write
    awvalid = 1'b1; awaddr = 32'h100;
    tick();
    awvalid = 1'b0;
    wdata = 32'h0; wstrb = 4'hF; wvalid = 1'b1;
    nrst = 1'b0;
    tick();
    nrst = 1'b1; wvalid = 1'b0;
    tick();
    chk("wrst_bvalid", 32'(bvalid), 32'd0);
    axi_read(32'h100, d, r, lat);
    chk("wrst_rdata", d, 32'hDEADAAEF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
